// File: rtl/reg_file_exp_pkg.sv
// rtl/reg_file_exp_pkg.sv - default widths and data-word type for the register file
package reg_file_exp_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage : reg_file_exp_pkg

// File: rtl/reg_file_exp_wdec.sv
// rtl/reg_file_exp_wdec.sv - write address plus strobe decoded to one-hot register enables
module reg_file_exp_wdec
    import reg_file_exp_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]      wa_i,
    input  logic                       we_i,
    output logic [(2**ADDR_WIDTH)-1:0] en_o
);

    always_comb begin
        en_o = '0;
        if (we_i) begin
            en_o[wa_i] = 1'b1;
        end
    end

endmodule : reg_file_exp_wdec

// File: rtl/reg_file_exp.sv
// rtl/reg_file_exp.sv - 2R1W register file, async active-low clear; REG_FILE_EXP_BYPASS_EN adds write-first forwarding
module reg_file_exp
    import reg_file_exp_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] RA1,
    input  logic [ADDR_WIDTH-1:0] RA2,
    input  logic [ADDR_WIDTH-1:0] WA,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      wr_en;

    reg_file_exp_wdec #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wdec (
        .wa_i (WA),
        .we_i (write_enable),
        .en_o (wr_en)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = wr_en[i] ? data_in : regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef REG_FILE_EXP_BYPASS_EN
    // Forwarding is gated by reset so both ports still read zero while cleared.
    logic fwd1;
    logic fwd2;

    assign fwd1      = write_enable && reset && (RA1 == WA);
    assign fwd2      = write_enable && reset && (RA2 == WA);
    assign data_out1 = fwd1 ? data_in : regs_q[RA1];
    assign data_out2 = fwd2 ? data_in : regs_q[RA2];
`else
    assign data_out1 = regs_q[RA1];
    assign data_out2 = regs_q[RA2];
`endif

endmodule : reg_file_exp

// File: tb/tb_reg_file_exp.sv
// tb/tb_reg_file_exp.sv - self-checking bench: vector table, corner sequences, random scoreboard
`timescale 1ns/1ps
module tb_reg_file_exp;

    logic [3:0] RA1, RA2, WA;
    logic [7:0] data_in;
    logic       clk;
    logic       reset;
    logic       write_enable;
    logic [7:0] data_out1, data_out2;

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] sb_q [$];
    logic [7:0]  mdl [16];

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] din;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vt [8];

    reg_file_exp dut (
        .RA1          (RA1),
        .RA2          (RA2),
        .WA           (WA),
        .data_in      (data_in),
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .data_out1    (data_out1),
        .data_out2    (data_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] din,
                         input logic [3:0] ra1, input logic [3:0] ra2);
        write_enable = we;
        WA           = wa;
        data_in      = din;
        RA1          = ra1;
        RA2          = ra2;
    endtask

    task automatic pop_check(input string name);
        logic [15:0] e;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty got %h expected entry", name, data_out1);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_p1"}, data_out1, e[15:8]);
            chk({name, "_p2"}, data_out2, e[7:0]);
        end
    endtask

    initial begin
        vt[0] = '{1'b1, 4'd0,  8'd5,   4'd0,  4'd2,  8'd5,   8'd0};
        vt[1] = '{1'b1, 4'd1,  8'd7,   4'd1,  4'd2,  8'd7,   8'd0};
        vt[2] = '{1'b1, 4'd5,  8'd13,  4'd1,  4'd0,  8'd7,   8'd5};
        vt[3] = '{1'b0, 4'd5,  8'd99,  4'd5,  4'd5,  8'd13,  8'd13};
        vt[4] = '{1'b0, 4'd1,  8'hFF,  4'd1,  4'd5,  8'd7,   8'd13};
        vt[5] = '{1'b1, 4'd15, 8'hFF,  4'd15, 4'd0,  8'hFF,  8'd5};
        vt[6] = '{1'b1, 4'd0,  8'h00,  4'd0,  4'd15, 8'h00,  8'hFF};
        vt[7] = '{1'b1, 4'd2,  8'h3C,  4'd2,  4'd1,  8'h3C,  8'd7};

        // Reset state, including a write attempted across an edge while held in reset
        reset = 1'b0;
        drive(1'b1, 4'd1, 8'hAA, 4'd1, 4'd2);
        #0.01;
        chk("reset_out1", data_out1, 8'h00);
        chk("reset_out2", data_out2, 8'h00);
        @(posedge clk); #1;
        chk("reset_wr_discard", data_out1, 8'h00);

        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vt[i].we, vt[i].wa, vt[i].din, vt[i].ra1, vt[i].ra2);
            sb_q.push_back({vt[i].e1, vt[i].e2});
            @(posedge clk); #1;
            pop_check($sformatf("vec%0d", i));
        end

        // Read of the address being written, before and after the edge
        @(negedge clk);
        drive(1'b1, 4'd3, 8'hA5, 4'd3, 4'd1);
        #1;
`ifdef REG_FILE_EXP_BYPASS_EN
        chk("raw_pre_edge", data_out1, 8'hA5);
`else
        chk("raw_pre_edge", data_out1, 8'h00);
`endif
        chk("raw_other_port", data_out2, 8'd7);
        @(posedge clk); #1;
        chk("raw_post_edge", data_out1, 8'hA5);

        // Async reset between edges in the middle of a write
        @(negedge clk);
        drive(1'b1, 4'd4, 8'h66, 4'd3, 4'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_out1", data_out1, 8'h00);
        chk("midreset_out2", data_out2, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 4'd0, 8'h00, 4'd4, 4'd3);
        #1;
        chk("pending_lost", data_out1, 8'h00);
        chk("cleared_reg3", data_out2, 8'h00);

        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;

        // First edge after release performs the write
        drive(1'b1, 4'd4, 8'h11, 4'd4, 4'd0);
        mdl[4] = 8'h11;
        @(posedge clk); #1;
        chk("resume_write", data_out1, 8'h11);
        chk("resume_other", data_out2, 8'h00);

        for (int i = 0; i < 40; i++) begin
            logic       we;
            logic [3:0] wa, ra1, ra2;
            logic [7:0] din;
            @(negedge clk);
            we  = 1'($urandom_range(0, 1));
            wa  = 4'($urandom_range(0, 15));
            ra1 = 4'($urandom_range(0, 15));
            ra2 = (i % 5 == 0) ? ra1 : 4'($urandom_range(0, 15));
            din = 8'($urandom_range(0, 255));
            drive(we, wa, din, ra1, ra2);
            if (we) mdl[wa] = din;
            sb_q.push_back({mdl[ra1], mdl[ra2]});
            @(posedge clk); #1;
            pop_check($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_reg_file_exp

// File: doc/reg_file_exp.md
REG_FILE_EXP -- requirements
Module: reg_file_exp

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bit width of each register and of each data port.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the address width; depth SHALL be 2**ADDR_WIDTH (16 registers).
REQ-003 Port order SHALL be RA1, RA2, WA, data_in, clk, reset, write_enable, data_out1, data_out2; positional instantiation SHALL remain valid.
REQ-004 clk, input, 1: single clock; all register state updates on its rising edge.
REQ-005 reset, input, 1: asynchronous, active-low reset.
REQ-006 RA1, input, ADDR_WIDTH: read address, port 1.
REQ-007 RA2, input, ADDR_WIDTH: read address, port 2.
REQ-008 WA, input, ADDR_WIDTH: write address.
REQ-009 data_in, input, DATA_WIDTH: write data.
REQ-010 write_enable, input, 1: active-high write strobe.
REQ-011 data_out1, output, DATA_WIDTH: contents of register RA1.
REQ-012 data_out2, output, DATA_WIDTH: contents of register RA2.

Function
REQ-013 Storage SHALL be 2**ADDR_WIDTH independent registers, each DATA_WIDTH bits wide; all registers are writable, with no hardwired-zero register.
REQ-014 On a rising clk edge with reset high and write_enable=1, register[WA] SHALL take data_in; no other register SHALL change.
REQ-015 With write_enable=0, a clk edge SHALL change no register.
REQ-016 Reads SHALL be combinational, with zero-cycle latency: data_out1=register[RA1] and data_out2=register[RA2], updating in the same delta as an address change.
REQ-017 Both read ports SHALL operate independently; RA1==RA2 SHALL return identical data on both ports.
REQ-018 Without bypass, a read of WA during a write SHALL return the old value until the clk edge and the new value immediately after it.
REQ-019 Writing an address while it is being read SHALL never corrupt any other port or register.
REQ-020 Address inputs SHALL span the full range; no out-of-range case exists.

Reset
REQ-021 While reset=0, all registers SHALL be cleared to 0 asynchronously, independent of clk.
REQ-022 Consequently data_out1 and data_out2 SHALL read 0 during reset.
REQ-023 A write coinciding with reset=0 SHALL be discarded.
REQ-024 Normal writes SHALL resume on the first rising clk edge after reset returns to 1.

Configuration
REQ-025 Macro REG_FILE_EXP_BYPASS_EN defined: when write_enable=1, reset=1 and RAn==WA, data_outn SHALL equal data_in combinationally, which is write-first forwarding, applied per port.
REQ-026 Macro undefined: no forwarding; REQ-018 applies.

Structure
REQ-027 Package reg_file_exp_pkg SHALL hold the default DATA_WIDTH/ADDR_WIDTH constants and a data-word typedef.
REQ-028 A sub-module reg_file_exp_wdec (WA plus write_enable decoded into one-hot per-register enables) is natural and SHALL be used.

Verification
REQ-029 reset=0 for 10 ps with RA1=1, RA2=2 -> data_out1=0, data_out2=0.
REQ-030 reset=1, write_enable=1, WA=0, data_in=5, one clk edge -> register0=5; RA1=0 reads 5.
REQ-031 WA=1, data_in=7, clk edge -> data_out1 (RA1=1) becomes 7 right after the edge; data_out2 (RA2=2) stays 0.
REQ-032 WA=5, data_in=13, clk edge, then write_enable=0 and RA2=5 -> data_out2=13 immediately; further edges with other data_in change nothing.
REQ-033 write_enable=1, WA=RA1=3, data_in=8'hA5 before the edge -> bypass build shows A5 before the edge; non-bypass build shows 0 before the edge and A5 after.
REQ-034 reset=0 asserted mid-write sequence, between edges -> all outputs 0 at once; the pending write is lost after release.
